// File: rtl/shift_pipe_if.sv
// ---------------------------------------------------------------------------
// shift_pipe_if
// Bundles the request, shifter-side and result handshake signals of
// shift_pipe.
//   slave  : the shift_pipe side (consumes requests, drives results)
//   master : the environment side (issues requests, consumes results, and
//            returns the combinational shifter output)
// Signals:
//   i_valid/o_ready        request handshake
//   i_op/i_data/i_shamt    request payload (00 SLL, 01 SRL, 11 SRA, 10 rsvd)
//   i_tag                  destination tag carried alongside the request
//   o_shf_data/o_shf_shamt operands driven into the left barrel shifter
//   i_shf_result           combinational shifter result
//   o_valid/i_ready        result handshake
//   o_result/o_tag         result payload
//   o_illegal              result came from the reserved opcode
// ---------------------------------------------------------------------------
interface shift_pipe_if #(
  parameter int TAG_W = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [31:0]      i_data;
  logic [4:0]       i_shamt;
  logic [TAG_W-1:0] i_tag;
  logic [31:0]      o_shf_data;
  logic [4:0]       o_shf_shamt;
  logic [31:0]      i_shf_result;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
  logic             o_illegal;

  modport slave (
    input  i_valid, i_op, i_data, i_shamt, i_tag, i_shf_result, i_ready,
    output o_ready, o_shf_data, o_shf_shamt, o_valid, o_result, o_tag, o_illegal
  );

  modport master (
    output i_valid, i_op, i_data, i_shamt, i_tag, i_shf_result, i_ready,
    input  o_ready, o_shf_data, o_shf_shamt, o_valid, o_result, o_tag, o_illegal
  );
endinterface

// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
// Two-stage shift execution unit wrapped around an external combinational
// left-only barrel shifter. Stage S1 registers the (pre-processed) operand
// and drives the shifter; stage S2 registers the post-processed result.
// Right shifts are done by reversing the operand, shifting left and
// reversing back; arithmetic right shifts additionally invert a negative
// operand before and after so that zeros shifted in become sign bits.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      shift_pipe_if.slave (request, shifter and result signals)
//   o_op_count (only with SHIFT_PIPE_CNT_EN) count of accepted results
// Optional feature: define SHIFT_PIPE_CNT_EN to add o_op_count, a wrapping
// 32-bit counter of results accepted downstream (reserved ops included).
// TAG_W must match the TAG_W of the connected interface instance.
// ---------------------------------------------------------------------------
module shift_pipe #(
  parameter int TAG_W = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  shift_pipe_if.slave bus
`ifdef SHIFT_PIPE_CNT_EN
  ,
  output logic [31:0] o_op_count
`endif
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  // Bit-order reversal, used on both sides of the left-only shifter.
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  logic             s1_valid_r;
  logic [31:0]      s1_data_r;
  logic [4:0]       s1_shamt_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [1:0]       s1_op_r;
  logic             s1_sign_r;

  logic             s2_valid_r;
  logic [31:0]      s2_result_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             s2_illegal_r;

  logic             s2_ready_s;
  logic             s1_ready_s;
  logic             s1_load_s;
  logic             s2_load_s;
  logic             in_sign_s;
  logic [31:0]      in_data_s;
  logic [31:0]      out_result_s;
  logic             out_illegal_s;

  // S2 frees up when empty or draining; S1 can refill whenever S2 can take
  // its current content, so drain and refill happen in the same cycle.
  assign s2_ready_s  = !s2_valid_r || bus.i_ready;
  assign s1_ready_s  = !s1_valid_r || s2_ready_s;
  assign s1_load_s   = bus.i_valid && s1_ready_s;
  assign s2_load_s   = s1_valid_r && s2_ready_s;

  assign bus.o_ready     = s1_ready_s;
  assign bus.o_shf_data  = s1_data_r;
  assign bus.o_shf_shamt = s1_shamt_r;
  assign bus.o_valid     = s2_valid_r;
  assign bus.o_result    = s2_result_r;
  assign bus.o_tag       = s2_tag_r;
  assign bus.o_illegal   = s2_illegal_r;

  // Operand pre-processing ahead of the issue register.
  always_comb begin
    in_sign_s = bus.i_data[31] && (bus.i_op == OP_SRA);
    in_data_s = bus.i_data;
    case (bus.i_op)
      OP_SLL:  in_data_s = bus.i_data;
      OP_SRL:  in_data_s = rev32(bus.i_data);
      OP_SRA:  in_data_s = rev32(bus.i_data ^ {32{in_sign_s}});
      default: in_data_s = bus.i_data;
    endcase
  end

  // Result post-processing of the shifter output for the op held in S1.
  always_comb begin
    out_result_s  = bus.i_shf_result;
    out_illegal_s = 1'b0;
    case (s1_op_r)
      OP_SLL: out_result_s = bus.i_shf_result;
      OP_SRL: out_result_s = rev32(bus.i_shf_result);
      OP_SRA: out_result_s = rev32(bus.i_shf_result) ^ {32{s1_sign_r}};
      default: begin
        out_result_s  = 32'd0;
        out_illegal_s = 1'b1;
      end
    endcase
  end

  // Issue stage: payload loads on accept and otherwise holds its last value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 32'd0;
      s1_shamt_r <= 5'd0;
      s1_tag_r   <= '0;
      s1_op_r    <= 2'b00;
      s1_sign_r  <= 1'b0;
    end else begin
      if (s1_load_s) begin
        s1_valid_r <= 1'b1;
        s1_data_r  <= in_data_s;
        s1_shamt_r <= bus.i_shamt;
        s1_tag_r   <= bus.i_tag;
        s1_op_r    <= bus.i_op;
        s1_sign_r  <= in_sign_s;
      end else if (s2_load_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
    end
  end

  // Result stage: payload stays frozen while the downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_r   <= 1'b0;
      s2_result_r  <= 32'd0;
      s2_tag_r     <= '0;
      s2_illegal_r <= 1'b0;
    end else begin
      if (s2_load_s) begin
        s2_valid_r   <= 1'b1;
        s2_result_r  <= out_result_s;
        s2_tag_r     <= s1_tag_r;
        s2_illegal_r <= out_illegal_s;
      end else if (bus.i_ready) begin
        s2_valid_r <= 1'b0;
      end else begin
        s2_valid_r <= s2_valid_r;
      end
    end
  end

`ifdef SHIFT_PIPE_CNT_EN
  logic [31:0] op_count_r;

  assign o_op_count = op_count_r;

  // Count results handed downstream; wraps naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_count_r <= 32'd0;
    end else if (s2_valid_r && bus.i_ready) begin
      op_count_r <= op_count_r + 32'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe
// Scoreboard bench for shift_pipe. A behavioural left shifter closes the
// loop on the shifter ports. The driver pushes the expected result of each
// accepted request (computed with plain >>, <<, >>> arithmetic); a separate
// monitor pops and compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_shift_pipe;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             lat_chk;
    int               acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  shift_pipe_if #(.TAG_W(TAG_W)) bus ();

`ifdef SHIFT_PIPE_CNT_EN
  logic [31:0] op_count;
  shift_pipe #(.TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_op_count(op_count)
  );
`else
  shift_pipe #(.TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational left barrel shifter.
  assign bus.i_shf_result = bus.o_shf_data << bus.o_shf_shamt;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_acc = 0;
  int          n_ret = 0;
  int          cyc = 0;
  int          ready_mode = 0;   // 0 always ready, 1 random, 2 stall window
  int          stall_left = 0;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_operand;
  logic [4:0]  pend_shamt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  // Reference result: what the instruction means, not how the unit does it.
  function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] d,
                                     input logic [4:0] s, input logic [TAG_W-1:0] t);
    exp_t e;
    logic signed [31:0] sd;
    sd = d;
    e = '0;
    e.tag = t;
    case (op)
      2'b00:   e.result = d << s;
      2'b01:   e.result = d >> s;
      2'b11:   e.result = sd >>> s;
      default: begin e.result = 32'd0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  // Operand the shifter must see for a given request.
  function automatic logic [31:0] ref_operand(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'b01:   return bitrev(d);
      2'b11:   return d[31] ? bitrev(~d) : bitrev(d);
      default: return d;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // One clock of driving: inputs change just after the edge, acceptance is
  // judged at the falling edge.
  task automatic cycle_step(input logic v, input logic [1:0] op, input logic [31:0] d,
                            input logic [4:0] s, input logic [TAG_W-1:0] t, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.i_valid = v;
    bus.i_op    = op;
    bus.i_data  = d;
    bus.i_shamt = s;
    bus.i_tag   = t;
    case (ready_mode)
      0: bus.i_ready = 1'b1;
      1: bus.i_ready = ($urandom_range(0, 3) != 0);
      default: begin
        bus.i_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    endcase
    #1;
    check("o_ready", 32'(bus.o_ready), 32'(!(((n_acc - n_ret) == 2) && !bus.i_ready)));
    if (pend_valid) begin
      check("shf_data", bus.o_shf_data, pend_operand);
      check("shf_shamt", 32'(bus.o_shf_shamt), 32'(pend_shamt));
    end
    @(negedge clk);
    acc = bus.i_valid && bus.o_ready;
    pend_valid = acc;
    if (acc) begin
      e = ref_model(op, d, s, t);
      e.lat_chk = (ready_mode == 0);
      e.acc_cyc = cyc + 1;
      sb_q.push_back(e);
      n_acc++;
      pend_operand = ref_operand(op, d);
      pend_shamt = s;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                      input logic [TAG_W-1:0] t);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) cycle_step(1'b1, op, d, s, t, acc);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    logic acc;
    cycle_step(1'b0, 2'b00, 32'd0, 5'd0, '0, acc);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((n_acc != n_ret) && (k < 50)) begin idle(); k++; end
    if (n_acc != n_ret) check("drain_timeout", 32'(n_ret), 32'(n_acc));
    idle();
  endtask

  // Monitor: compares every handed-over result and watches stall stability.
  initial begin
    exp_t        e;
    logic        hold_chk;
    logic [31:0] h_res;
    logic [TAG_W-1:0] h_tag;
    logic        h_ill;
    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check("hold_valid", 32'(bus.o_valid), 32'd1);
          check("hold_result", bus.o_result, h_res);
          check("hold_tag", 32'(bus.o_tag), 32'(h_tag));
          check("hold_illegal", 32'(bus.o_illegal), 32'(h_ill));
        end
        hold_chk = bus.o_valid && !bus.i_ready;
        h_res = bus.o_result;
        h_tag = bus.o_tag;
        h_ill = bus.o_illegal;
        if (bus.o_valid && bus.i_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_result", 32'(bus.o_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("result", bus.o_result, e.result);
            check("tag", 32'(bus.o_tag), 32'(e.tag));
            check("illegal", 32'(bus.o_illegal), 32'(e.illegal));
            if (e.lat_chk) check("latency", 32'(cyc + 1), 32'(e.acc_cyc + 2));
          end
          n_ret++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_op = 2'b00;
    bus.i_data = 32'd0;
    bus.i_shamt = 5'd0;
    bus.i_tag = '0;
    bus.i_ready = 1'b1;
    #23;
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_result", bus.o_result, 32'd0);
    check("rst_o_tag", 32'(bus.o_tag), 32'd0);
    check("rst_o_illegal", 32'(bus.o_illegal), 32'd0);
    check("rst_shf_data", bus.o_shf_data, 32'd0);
    check("rst_shf_shamt", 32'(bus.o_shf_shamt), 32'd0);
    check("rst_o_ready", 32'(bus.o_ready), 32'd1);
`ifdef SHIFT_PIPE_CNT_EN
    check("rst_count", op_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including the shamt boundaries and the reserved op.
    ready_mode = 0;
    send(2'b00, 32'h0000_0001, 5'd31, 5'd3);
    send(2'b01, 32'h8000_0000, 5'd4, 5'd1);
    send(2'b11, 32'h8000_0000, 5'd4, 5'd2);
    send(2'b11, 32'h7FFF_FFF0, 5'd4, 5'd4);
    send(2'b10, 32'h1234_5678, 5'd7, 5'd5);
    send(2'b00, 32'hA5A5_A5A5, 5'd0, 5'd6);
    send(2'b01, 32'hC3C3_0F0F, 5'd0, 5'd7);
    send(2'b11, 32'h9000_0001, 5'd0, 5'd8);
    send(2'b11, 32'h8000_1234, 5'd31, 5'd9);
    send(2'b01, 32'hFFFF_FFFF, 5'd31, 5'd10);
    wait_idle();

    // Back-to-back stream with the downstream always ready.
    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 5'(i));
    wait_idle();

    // Five stalled cycles with three requests offered.
    ready_mode = 2;
    stall_left = 5;
    send(2'b11, 32'hF0F0_0000, 5'd8, 5'd11);
    send(2'b01, 32'h0000_F0F0, 5'd3, 5'd12);
    send(2'b00, 32'h0000_0F0F, 5'd12, 5'd13);
    wait_idle();

    // Random traffic with random backpressure and idle gaps.
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom));
    end
    ready_mode = 0;
    wait_idle();
`ifdef SHIFT_PIPE_CNT_EN
    check("count_total", op_count, 32'(n_ret));
`endif

    // Reset with two ops in flight.
    ready_mode = 2;
    stall_left = 10;
    send(2'b00, 32'h0000_0003, 5'd1, 5'd14);
    send(2'b00, 32'h0000_0005, 5'd2, 5'd15);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    #2;
    check("inflight_valid", 32'(bus.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.o_valid), 32'd0);
    check("async_rst_ready", 32'(bus.o_ready), 32'd1);
    sb_q.delete();
    n_acc = 0;
    n_ret = 0;
    pend_valid = 1'b0;
    stall_left = 0;
    ready_mode = 0;
`ifdef SHIFT_PIPE_CNT_EN
    check("count_rst", op_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("post_rst_valid", 32'(bus.o_valid), 32'd0);
    send(2'b11, 32'h8000_0000, 5'd31, 5'd16);
    send(2'b10, 32'h0000_0001, 5'd1, 5'd17);
    send(2'b01, 32'h0000_0100, 5'd8, 5'd18);
    wait_idle();
`ifdef SHIFT_PIPE_CNT_EN
    check("count_three", op_count, 32'd3);
`endif
    acc = 1'b0;
    if (acc) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Two-stage pipelined shift execution unit that sits directly upstream of the combinational left barrel shifter (sll_shifter) and consumes its result.
- Captures a shift request (SLL/SRL/SRA) under valid/ready handshake and drives the shifter's data/shamt inputs from a registered issue stage.
- Implements right shifts on the left-only shifter by bit reversal, with sign handling by inversion.
- Registers the post-processed result with a destination tag toward writeback.

Parameters:
- TAG_W, 5, width of pass-through destination tag (rd index)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  request valid
- o_ready  output  1  unit can accept request this cycle
- i_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
- i_data  input  32  operand
- i_shamt  input  5  shift amount
- i_tag  input  TAG_W  destination tag
- o_shf_data  output  32  to shifter i_data
- o_shf_shamt  output  5  to shifter i_shamt
- i_shf_result  input  32  from shifter o_result (combinational)
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_result  output  32  shift result
- o_tag  output  TAG_W  tag of result
- o_illegal  output  1  result came from reserved op

Behaviour:
- Reset (async, i_rst_n=0): all valid flags 0; o_valid=0, o_result=0, o_tag=0, o_illegal=0, o_shf_data=0, o_shf_shamt=0. Deassertion is synchronised by the system. Reset mid-operation discards in-flight ops.
- Stage S1 (issue reg) and S2 (result reg), each with its own valid bit.
- s2_ready = !s2_valid || i_ready.
- s1_ready = !s1_valid || s2_ready.
- o_ready = s1_ready, combinational, with no dependency on i_valid.
- S1 load (i_valid && o_ready), for sign = i_data[31] && op==11:
  - SLL: shf_data = i_data.
  - SRL: shf_data = rev(i_data).
  - SRA: shf_data = rev(i_data ^ {32{sign}}).
  - Reserved: shf_data = i_data.
  - Also store shamt, tag, op, sign.
- o_shf_data/o_shf_shamt come directly from S1 registers. The shifter is combinational; S2 samples i_shf_result in the same cycle.
- S2 load (s1_valid && s2_ready):
  - SLL: result = i_shf_result.
  - SRL: result = rev(i_shf_result).
  - SRA: result = rev(i_shf_result) ^ {32{sign}}.
  - Reserved: result = 0, o_illegal = 1.
  - o_illegal = 0 for all other ops. Tag copied.
- Latency: accept at edge N, o_valid at edge N+2. Throughput is 1/cycle with i_ready held 1.
- Backpressure: while o_valid && !i_ready, o_result/o_tag/o_illegal are held stable. S1 holds while S2 is stalled. At most 2 ops in flight; o_ready=0 when both are full and i_ready=0.
- Simultaneous S2 drain and S1 refill in the same cycle is legal, with no bubble.
- S1 invalid: S1 registers hold their last values (no clearing required).
- shamt=0: result equals i_data for all legal ops. shamt=31: SRA of a negative value yields 0xFFFFFFFF.

Optional Feature:
- Macro SHIFT_PIPE_CNT_EN.
- When defined:
  - Adds port o_op_count, output, 32 bits.
  - Counts S2 results accepted (o_valid && i_ready).
  - Reset to 0; wraps 0xFFFFFFFF→0.
  - Reserved-op results are counted.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- SLL 0x0000_0001, shamt 31, tag 3, i_ready=1 → o_valid 2 cycles after accept; o_result 0x8000_0000; o_tag 3; o_illegal 0.
- SRL 0x8000_0000, shamt 4 → 0x0800_0000. SRA 0x8000_0000, shamt 4 → 0xF800_0000. SRA 0x7FFF_FFF0, shamt 4 → 0x07FF_FFFF.
- Back-to-back stream of 8 ops with i_ready=1 → o_ready stays 1; results in order, one per cycle; shifter driven with correct reversed operand each cycle.
- i_ready=0 for 5 cycles with 3 requests offered → 2 accepted, o_ready=0 afterwards, o_result stable. On release the third op is accepted and order is preserved.
- op=10, data 0x1234_5678 → o_result 0, o_illegal 1. The next SLL op produces o_illegal 0.
- Assert i_rst_n=0 with 2 ops in flight → o_valid 0 immediately (async). With SHIFT_PIPE_CNT_EN, o_op_count returns to 0 and counts 3 after 3 accepted results.
